// File: rtl/isp_cfg_shadow_ctrl_if.sv
// rtl/isp_cfg_shadow_ctrl_if.sv - control write bus, stream tap and readback bundle for isp_cfg_shadow_ctrl
interface isp_cfg_shadow_ctrl_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        in_valid;
  logic [7:0]  in_user;
  logic        commit_now;
  logic        hold;
  logic [3:0]  rd_addr;
  logic        rd_bank;
  logic [15:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, in_valid, in_user, commit_now, hold, rd_addr, rd_bank,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, in_valid, in_user, commit_now, hold, rd_addr, rd_bank,
    output rd_data
  );
endinterface

// File: rtl/isp_cfg_shadow_ctrl.sv
// rtl/isp_cfg_shadow_ctrl.sv - frame-synchronous shadow/active config bank controller
// Optional readback path enabled by ISP_CFG_READBACK_EN.
module isp_cfg_shadow_ctrl #(
  parameter int            NUM_REGS   = 16,
  parameter logic [255:0]  RST_VECTOR = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  isp_cfg_shadow_ctrl_if.slave         cfg,
  output logic [NUM_REGS-1:0][15:0]    isp_vector_o,
  output logic                         pending_o,
  output logic                         committing_o,
  output logic [15:0]                  frame_cnt_o,
  output logic                         wr_err_o
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [NUM_REGS-1:0][15:0]   shadow_q, shadow_d;
  logic [NUM_REGS-1:0][15:0]   active_q, active_d;
  logic [15:0]                 frame_cnt_q, frame_cnt_d;
  logic                        wr_err_q, wr_err_d;

  logic in_range, wr_ok, fstart, trigger;

  assign in_range = cfg.wr_addr < 16'(NUM_REGS);
  assign wr_ok    = cfg.wr_en && in_range;
  assign fstart   = cfg.in_valid && cfg.in_user[1];
  assign trigger  = (fstart || cfg.commit_now) && !cfg.hold;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_ok) state_d = PENDING;
      PENDING: if (trigger) state_d = COMMIT;
      COMMIT:  state_d = wr_ok ? PENDING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Active snapshots the pre-edge shadow, so a write landing in the COMMIT cycle stays pending.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && cfg.wr_addr[3:0] == 4'(i)) shadow_d[i] = cfg.wr_data;
    end
    active_d    = (state_q == COMMIT) ? shadow_q : active_q;
    frame_cnt_d = frame_cnt_q + 16'(fstart);
    wr_err_d    = wr_err_q | (cfg.wr_en && !in_range);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      wr_err_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RST_VECTOR[16*i +: 16];
        active_q[i] <= RST_VECTOR[16*i +: 16];
      end
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      wr_err_q    <= wr_err_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  assign isp_vector_o = active_q;
  assign pending_o    = (state_q != IDLE);
  assign committing_o = (state_q == COMMIT);
  assign frame_cnt_o  = frame_cnt_q;
  assign wr_err_o     = wr_err_q;

`ifdef ISP_CFG_READBACK_EN
  logic [15:0] rd_sel, rd_data_q;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cfg.rd_addr == 4'(i)) rd_sel = cfg.rd_bank ? shadow_q[i] : active_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rd_data_q <= '0;
    else         rd_data_q <= rd_sel;
  end

  assign cfg.rd_data = rd_data_q;

  logic unused_user;
  assign unused_user = ^{cfg.in_user[7:2], cfg.in_user[0]};
`else
  assign cfg.rd_data = '0;

  logic unused_user;
  assign unused_user = ^{cfg.in_user[7:2], cfg.in_user[0], cfg.rd_addr, cfg.rd_bank};
`endif

endmodule

// File: tb/tb_isp_cfg_shadow_ctrl.sv
// tb/tb_isp_cfg_shadow_ctrl.sv - directed self-checking bench for isp_cfg_shadow_ctrl
module tb_isp_cfg_shadow_ctrl;

  function automatic logic [255:0] mk_rstv();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'h1000 + 16'(i);
    return v;
  endfunction

  localparam logic [255:0] RSTV = mk_rstv();

  logic               clk = 1'b0;
  logic               reset;
  logic [15:0][15:0]  isp_vec;
  logic               pending, committing, wr_err;
  logic [15:0]        frame_cnt;
  logic [255:0]       exp_vec;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  isp_cfg_shadow_ctrl_if cfg_if ();

  isp_cfg_shadow_ctrl #(.NUM_REGS(16), .RST_VECTOR(RSTV)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cfg          (cfg_if),
    .isp_vector_o (isp_vec),
    .pending_o    (pending),
    .committing_o (committing),
    .frame_cnt_o  (frame_cnt),
    .wr_err_o     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    cfg_if.wr_en   = 1'b1;
    cfg_if.wr_addr = addr;
    cfg_if.wr_data = data;
    cyc();
    cfg_if.wr_en   = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    cfg_if.wr_en      = 1'b0;
    cfg_if.wr_addr    = '0;
    cfg_if.wr_data    = '0;
    cfg_if.in_valid   = 1'b0;
    cfg_if.in_user    = '0;
    cfg_if.commit_now = 1'b0;
    cfg_if.hold       = 1'b0;
    cfg_if.rd_addr    = '0;
    cfg_if.rd_bank    = 1'b0;
    exp_vec           = RSTV;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_vec", isp_vec, exp_vec);
    chk("rst_pending", pending, 0);
    chk("rst_committing", committing, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_rd_data", cfg_if.rd_data, 0);

    // write reg3 then fstart: new value visible two edges after the trigger cycle
    wr(16'd3, 16'h00A5);
    chk("w3_pending", pending, 1);
    chk("w3_isp3_old", isp_vec[3], 16'h1003);
    cfg_if.in_valid = 1'b1;
    cfg_if.in_user  = 8'hFD;
    cyc();
    chk("no_fstart_bit", frame_cnt, 0);
    chk("no_fstart_commit", committing, 0);
    cfg_if.in_user = 8'h02;
    cyc();
    chk("t1_committing", committing, 1);
    chk("t1_isp3_old", isp_vec[3], 16'h1003);
    chk("t1_frame_cnt", frame_cnt, 1);
    cfg_if.in_valid = 1'b0;
    cyc();
    exp_vec[16*3 +: 16] = 16'h00A5;
    chk("t2_vec", isp_vec, exp_vec);
    chk("t2_pending", pending, 0);
    chk("t2_committing", committing, 0);

    // write in trigger cycle included, write in COMMIT cycle excluded
    wr(16'd1, 16'h7777);
    cfg_if.wr_en    = 1'b1;
    cfg_if.wr_addr  = 16'd2;
    cfg_if.wr_data  = 16'h1111;
    cfg_if.in_valid = 1'b1;
    cyc();
    chk("ord_committing", committing, 1);
    chk("ord_frame_cnt", frame_cnt, 2);
    cfg_if.wr_data  = 16'h2222;
    cfg_if.in_valid = 1'b0;
    cyc();
    cfg_if.wr_en = 1'b0;
    exp_vec[16*1 +: 16] = 16'h7777;
    exp_vec[16*2 +: 16] = 16'h1111;
    chk("ord_vec", isp_vec, exp_vec);
    chk("ord_pending", pending, 1);
    chk("ord_committing_off", committing, 0);
    cfg_if.in_valid = 1'b1;
    cyc();
    chk("ord2_committing", committing, 1);
    cfg_if.in_valid = 1'b0;
    cyc();
    exp_vec[16*2 +: 16] = 16'h2222;
    chk("ord2_vec", isp_vec, exp_vec);
    chk("ord2_pending", pending, 0);
    chk("ord2_frame_cnt", frame_cnt, 3);

    // hold drops triggers; commit_now after release
    wr(16'd0, 16'hABCD);
    cfg_if.hold     = 1'b1;
    cfg_if.in_valid = 1'b1;
    cyc();
    chk("hold_a_committing", committing, 0);
    cfg_if.in_valid = 1'b0;
    cyc();
    cfg_if.in_valid = 1'b1;
    cyc();
    chk("hold_b_committing", committing, 0);
    cfg_if.in_valid = 1'b0;
    cyc();
    chk("hold_frame_cnt", frame_cnt, 5);
    chk("hold_vec", isp_vec, exp_vec);
    chk("hold_pending", pending, 1);
    cfg_if.hold = 1'b0;
    cyc();
    chk("unhold_no_commit", committing, 0);
    cfg_if.commit_now = 1'b1;
    cyc();
    chk("cnow_committing", committing, 1);
    chk("cnow_isp0_old", isp_vec[0], 16'h1000);
    cfg_if.commit_now = 1'b0;
    cyc();
    exp_vec[16*0 +: 16] = 16'hABCD;
    chk("cnow_vec", isp_vec, exp_vec);
    chk("cnow_pending", pending, 0);

    // trigger while idle does nothing
    cfg_if.commit_now = 1'b1;
    cyc();
    cfg_if.commit_now = 1'b0;
    chk("idle_trigger", committing, 0);

    // simultaneous fstart and commit_now: exactly one commit
    wr(16'd4, 16'h4444);
    cfg_if.commit_now = 1'b1;
    cfg_if.in_valid   = 1'b1;
    cyc();
    chk("sim_committing", committing, 1);
    chk("sim_frame_cnt", frame_cnt, 6);
    cfg_if.commit_now = 1'b0;
    cfg_if.in_valid   = 1'b0;
    cyc();
    exp_vec[16*4 +: 16] = 16'h4444;
    chk("sim_vec", isp_vec, exp_vec);
    chk("sim_state", {committing, pending}, 2'b00);
    cyc();
    chk("sim_single", committing, 0);

    // out-of-range writes
    wr(16'h0010, 16'hFFFF);
    chk("oor_wr_err", wr_err, 1);
    chk("oor_pending", pending, 0);
    chk("oor_vec", isp_vec, exp_vec);
    wr(16'hFFFF, 16'h5A5A);
    cyc();
    cyc();
    chk("oor_sticky", wr_err, 1);
    chk("oor_vec2", isp_vec, exp_vec);

    // readback of shadow vs active banks
    wr(16'd5, 16'hBEEF);
    cfg_if.rd_addr = 4'd5;
    cfg_if.rd_bank = 1'b1;
    cyc();
`ifdef ISP_CFG_READBACK_EN
    chk("rb_shadow", cfg_if.rd_data, 16'hBEEF);
`else
    chk("rb_shadow", cfg_if.rd_data, 16'h0000);
`endif
    cfg_if.rd_bank = 1'b0;
    cyc();
`ifdef ISP_CFG_READBACK_EN
    chk("rb_active_old", cfg_if.rd_data, 16'h1005);
`else
    chk("rb_active_old", cfg_if.rd_data, 16'h0000);
`endif
    cfg_if.commit_now = 1'b1;
    cyc();
    cfg_if.commit_now = 1'b0;
    cyc();
    cyc();
`ifdef ISP_CFG_READBACK_EN
    chk("rb_active_new", cfg_if.rd_data, 16'hBEEF);
`else
    chk("rb_active_new", cfg_if.rd_data, 16'h0000);
`endif
    exp_vec[16*5 +: 16] = 16'hBEEF;
    chk("rb_vec", isp_vec, exp_vec);

    // reset during COMMIT wins
    wr(16'd6, 16'h6666);
    cfg_if.commit_now = 1'b1;
    cyc();
    chk("rc_committing", committing, 1);
    cfg_if.commit_now = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_vec = RSTV;
    chk("rc_vec", isp_vec, exp_vec);
    chk("rc_state", {committing, pending}, 2'b00);
    chk("rc_wr_err", wr_err, 0);
    chk("rc_frame_cnt", frame_cnt, 0);
    cyc();
    chk("rc_vec_hold", isp_vec, exp_vec);

    // frame counter wrap
    cfg_if.in_valid = 1'b1;
    cfg_if.in_user  = 8'h02;
    repeat (65535) cyc();
    chk("wrap_max", frame_cnt, 16'hFFFF);
    cyc();
    chk("wrap_zero", frame_cnt, 16'h0000);
    cfg_if.in_valid = 1'b0;
    chk("wrap_vec", isp_vec, exp_vec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/isp_cfg_shadow_ctrl.md
Name: isp_cfg_shadow_ctrl

Overview:
Frame-synchronous configuration controller for the ISP pipeline. Register writes land in a shadow bank. The shadow bank is committed to the active bank (isp_vector, which drives every ISP stage) only at a frame start or on a forced commit. This ensures no stage sees its configuration change mid-frame. The block sits between the control write bus and all ISP stages, and observes the adapter output stream (valid/user) to detect frame starts.

Parameters:
NUM_REGS, 16, number of 16-bit configuration registers (max 16; the address index is 4 bits)
RST_VECTOR, 256'h0, reset value of shadow and active banks; register i = RST_VECTOR[16*i+15:16*i]

Ports:
clk  input  1  ISP clock; all logic is on this single clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  write strobe, one write per cycle
wr_addr  input  16  register index; values >= NUM_REGS are ignored and set wr_err
wr_data  input  16  write data
in_valid  input  1  adapter output valid (stream tap only; no backpressure)
in_user  input  8  adapter output user; [1] = fstart
commit_now  input  1  force a commit regardless of frame position
hold  input  1  while high, defer all commits (pending is kept)
isp_vector  output  16x16  active bank, registered
pending  output  1  shadow bank differs from active bank (an uncommitted write exists)
committing  output  1  high during the COMMIT state cycle
frame_cnt  output  16  count of fstart beats seen; wraps at 16'hFFFF -> 0
wr_err  output  1  sticky flag for an out-of-range write; cleared only by reset
rd_addr  input  4  readback index (feature-dependent)
rd_bank  input  1  readback bank select: 0 = active, 1 = shadow
rd_data  output  16  readback data

Behaviour:
- Reset (sync): shadow = active = RST_VECTOR; state IDLE; pending = 0; committing = 0; frame_cnt = 0; wr_err = 0; rd_data = 0.
- Writes: when wr_en is high and wr_addr < NUM_REGS, shadow[wr_addr] <= wr_data at the clock edge; pending <= 1. Writing the same value still sets pending. Out of range: no shadow change; wr_err <= 1.
- fstart event = in_valid && in_user[1]. On each fstart event, frame_cnt increments by 1.
- Trigger = (fstart event || commit_now) && !hold. Simultaneous fstart and commit_now produce one commit.
- FSM:
  - IDLE: on a write -> PENDING. A trigger in IDLE has no effect.
  - PENDING: on trigger -> COMMIT.
  - COMMIT: lasts 1 cycle; committing = 1; at the end of the cycle, active <= shadow (whole bank).
    - Next state: PENDING if a write occurs during the COMMIT cycle, else IDLE.
    - pending = 0 after COMMIT unless a write occurred during the COMMIT cycle.
- Latency: trigger at cycle T -> COMMIT at T+1 -> new isp_vector visible at T+2. Downstream stages see fstart at least 2 row-times later (window line buffers), so the whole frame uses the new config.
- Write ordering:
  - A write in the trigger cycle T is included in the commit.
  - A write in the COMMIT cycle is excluded: the snapshot is the pre-write shadow; that write stays pending for the next trigger.
- hold: a trigger while hold = 1 is dropped, not queued. Commit then happens at the next fstart or commit_now after hold falls.
- Reset during COMMIT: reset wins; both banks return to RST_VECTOR.
- isp_vector changes only on the COMMIT edge or on reset. Writes never alter it directly.

Optional Feature:
- Macro ISP_CFG_READBACK_EN.
- Defined: rd_data <= (rd_bank ? shadow[rd_addr] : active[rd_addr]), 1-cycle latency; rd_addr >= NUM_REGS returns 16'h0000.
- Undefined: rd_data tied to 16'h0000; rd_addr and rd_bank are unused; no read mux is synthesized.

Test Plan:
- Reset then idle: isp_vector == RST_VECTOR, pending = 0, frame_cnt = 0.
- Write reg3 = 16'h00A5 mid-frame, then fstart at cycle T: isp_vector[3] unchanged until T+2, equals 16'h00A5 at T+2; pending falls at T+2; frame_cnt = 1.
- Write reg2 = 16'h1111 in cycle T (trigger cycle) and reg2 = 16'h2222 in the COMMIT cycle: active reg2 = 16'h1111, pending = 1; the next fstart commits 16'h2222.
- hold = 1 across two fstart beats with a pending write to reg0: no commit, frame_cnt = 2; hold drops, then commit_now -> reg0 updated 2 cycles later.
- Write with wr_addr = 16'h0010: no bank change, wr_err = 1 and stays 1 until reset; 65536 fstart beats -> frame_cnt wraps to 0.
- With ISP_CFG_READBACK_EN: write reg5 = 16'hBEEF; rd_bank = 1 returns 16'hBEEF, rd_bank = 0 returns the old value until commit; without the macro, rd_data == 0 always.
